// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read master between the audio streamer (port 0) and chart fetcher (port 1).
// Define ARB_TIMEOUT_EN to abort READs that exceed TIMEOUT cycles and raise a sticky timeout_err.
module sdram_read_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_rdv,
    output logic [DATA_W-1:0] req0_data,
    input  logic              req1,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_rdv,
    output logic [DATA_W-1:0] req1_data,
    output logic              tl_read,
    output logic              tl_write,
    output logic [ADDR_W-1:0] tl_addr,
    input  logic              tl_rdv,
    input  logic [DATA_W-1:0] sample,
    output logic              busy,
    output logic              grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              lastGrant_q, lastGrant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic              pick;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
`endif

    // On a tie, the port that did not win last time gets the bus.
    assign pick = (req0 && req1) ? ~lastGrant_q : req1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            addr_q      <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        addr_d      = addr_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = READ;
                    grant_d     = pick;
                    lastGrant_d = pick;
                    addr_d      = pick ? req1_addr : req0_addr;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            READ: begin
                // A real tl_rdv beats the timeout when both land on the same cycle.
                if (tl_rdv) begin
                    if (grant_q) data1_d = sample;
                    else         data0_d = sample;
                    state_d = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    if (grant_q) data1_d = '0;
                    else         data0_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign tl_read   = (state_q == READ);
    assign tl_write  = 1'b0;
    assign tl_addr   = (state_q == READ) ? addr_q : '0;
    assign req0_rdv  = (state_q == DONE) && !grant_q;
    assign req1_rdv  = (state_q == DONE) && grant_q;
    assign req0_data = data0_q;
    assign req1_data = data1_q;
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Self-checking bench for sdram_read_arbiter: transaction-level model compared every cycle plus directed literal checks.
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined.
module tb_sdram_read_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic        req0_rdv, req1_rdv;
    logic [31:0] req0_data, req1_data;
    logic        tl_read, tl_write;
    logic [31:0] tl_addr;
    logic        tl_rdv = 1'b0;
    logic [31:0] sample = '0;
    logic        busy, grant, timeout_err;

    int nChecks = 0;
    int nFails  = 0;

    sdram_read_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req0_addr(req0_addr), .req0_rdv(req0_rdv), .req0_data(req0_data),
        .req1(req1), .req1_addr(req1_addr), .req1_rdv(req1_rdv), .req1_data(req1_data),
        .tl_read(tl_read), .tl_write(tl_write), .tl_addr(tl_addr),
        .tl_rdv(tl_rdv), .sample(sample),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    // Transaction model: at most one read in flight, followed by one completion cycle.
    logic        mInFlight, mCompleting, mPort, mLastWinner, mErr;
    logic [31:0] mAddr, mData0, mData1;
    int          mWait;
    logic        mWinner;

    assign mWinner = (req0 && req1) ? !mLastWinner : req1;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mInFlight   <= 1'b0;
            mCompleting <= 1'b0;
            mPort       <= 1'b0;
            mLastWinner <= 1'b1;
            mErr        <= 1'b0;
            mAddr       <= '0;
            mData0      <= '0;
            mData1      <= '0;
            mWait       <= 0;
        end else if (mCompleting) begin
            mCompleting <= 1'b0;
        end else if (mInFlight) begin
            if (tl_rdv) begin
                if (mPort) mData1 <= sample;
                else       mData0 <= sample;
                mInFlight   <= 1'b0;
                mCompleting <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (mWait == TB_TIMEOUT) begin
                if (mPort) mData1 <= '0;
                else       mData0 <= '0;
                mErr        <= 1'b1;
                mInFlight   <= 1'b0;
                mCompleting <= 1'b1;
            end
`endif
            else begin
                mWait <= mWait + 1;
            end
        end else if (req0 || req1) begin
            mPort       <= mWinner;
            mLastWinner <= mWinner;
            mAddr       <= mWinner ? req1_addr : req0_addr;
            mInFlight   <= 1'b1;
            mWait       <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge Clk) begin
        checkOutput("m.tl_read",     64'(tl_read),     64'(mInFlight));
        checkOutput("m.tl_write",    64'(tl_write),    64'(0));
        checkOutput("m.tl_addr",     64'(tl_addr),     64'(mInFlight ? mAddr : 32'h0));
        checkOutput("m.req0_rdv",    64'(req0_rdv),    64'(mCompleting && !mPort));
        checkOutput("m.req1_rdv",    64'(req1_rdv),    64'(mCompleting && mPort));
        checkOutput("m.req0_data",   64'(req0_data),   64'(mData0));
        checkOutput("m.req1_data",   64'(req1_data),   64'(mData1));
        checkOutput("m.busy",        64'(busy),        64'(mInFlight || mCompleting));
        checkOutput("m.grant",       64'(grant),       64'(mPort));
        checkOutput("m.timeout_err", 64'(timeout_err), 64'(mErr));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulseReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic waitRead(input int limit);
        int n = 0;
        while (tl_read !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("waitRead", 64'(tl_read), 64'(1));
    endtask

    task automatic applyStimulus();
        // Reset state
        tick();
        checkOutput("rst.tl_read", 64'(tl_read), 64'(0));
        checkOutput("rst.grant", 64'(grant), 64'(0));
        checkOutput("rst.busy", 64'(busy), 64'(0));
        checkOutput("rst.req0_data", 64'(req0_data), 64'(0));
        tick();
        Reset = 1'b0;

        // Single port read
        req0 = 1'b1; req0_addr = 32'h10;
        tick();
        checkOutput("single.tl_read", 64'(tl_read), 64'(1));
        checkOutput("single.tl_addr", 64'(tl_addr), 64'h10);
        checkOutput("single.busy", 64'(busy), 64'(1));
        tick();
        tick();
        req0 = 1'b0; tl_rdv = 1'b1; sample = 32'hDEADBEEF;
        tick();
        tl_rdv = 1'b0;
        checkOutput("single.req0_rdv", 64'(req0_rdv), 64'(1));
        checkOutput("single.req0_data", 64'(req0_data), 64'hDEADBEEF);
        checkOutput("single.req1_rdv", 64'(req1_rdv), 64'(0));
        checkOutput("single.tl_read_done", 64'(tl_read), 64'(0));
        tick();
        checkOutput("single.rdv_once", 64'(req0_rdv), 64'(0));
        checkOutput("single.idle_busy", 64'(busy), 64'(0));

        // Tie from reset: grants alternate 0,1,0,1
        Reset = 1'b1;
        req0 = 1'b1; req0_addr = 32'h100;
        req1 = 1'b1; req1_addr = 32'h200;
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitRead(10);
            checkOutput("tie.grant", 64'(grant), 64'(k % 2));
            checkOutput("tie.tl_addr", 64'(tl_addr), (k % 2) ? 64'h200 : 64'h100);
            tl_rdv = 1'b1; sample = 32'hA0 + 32'(k);
            tick();
            tl_rdv = 1'b0;
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            checkOutput("tie.rdv", 64'((k % 2) ? req1_rdv : req0_rdv), 64'(1));
            checkOutput("tie.other_rdv", 64'((k % 2) ? req0_rdv : req1_rdv), 64'(0));
            checkOutput("tie.data", 64'((k % 2) ? req1_data : req0_data), 64'(32'hA0 + 32'(k)));
            tick();
        end
        checkOutput("tie.stop", 64'(tl_read), 64'(0));

        // tl_rdv in IDLE is ignored
        tl_rdv = 1'b1; sample = 32'hBAD;
        tick();
        tl_rdv = 1'b0;
        tick();
        checkOutput("idle_rdv.data0", 64'(req0_data), 64'hA2);
        checkOutput("idle_rdv.data1", 64'(req1_data), 64'hA3);

        // Drop mid-read and address change after grant
        req1 = 1'b1; req1_addr = 32'h30;
        tick();
        checkOutput("drop.grant", 64'(grant), 64'(1));
        checkOutput("drop.tl_addr", 64'(tl_addr), 64'h30);
        req1 = 1'b0; req1_addr = 32'h999;
        tick();
        checkOutput("drop.addr_held", 64'(tl_addr), 64'h30);
        tl_rdv = 1'b1; sample = 32'h1234;
        tick();
        tl_rdv = 1'b0;
        checkOutput("drop.req1_rdv", 64'(req1_rdv), 64'(1));
        checkOutput("drop.req1_data", 64'(req1_data), 64'h1234);
        checkOutput("drop.req0_data", 64'(req0_data), 64'hA2);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("drop.no_read", 64'(tl_read), 64'(0));
        end

        // Reset mid-READ, then a late tl_rdv
        req0 = 1'b1; req0_addr = 32'h40;
        tick();
        checkOutput("rmid.in_read", 64'(tl_read), 64'(1));
        Reset = 1'b1; req0 = 1'b0;
        #1;
        checkOutput("rmid.tl_read", 64'(tl_read), 64'(0));
        checkOutput("rmid.tl_addr", 64'(tl_addr), 64'(0));
        checkOutput("rmid.data1", 64'(req1_data), 64'(0));
        checkOutput("rmid.busy", 64'(busy), 64'(0));
        tick();
        Reset = 1'b0; tl_rdv = 1'b1; sample = 32'h55;
        tick();
        tl_rdv = 1'b0;
        checkOutput("rmid.no_rdv", 64'(req0_rdv), 64'(0));
        checkOutput("rmid.data0", 64'(req0_data), 64'(0));
        checkOutput("rmid.idle", 64'(busy), 64'(0));
        tick();

`ifdef ARB_TIMEOUT_EN
        // Timeout abort after a normal read so the zeroed data is observable
        req0 = 1'b1; req0_addr = 32'h60;
        tick();
        req0 = 1'b0; tl_rdv = 1'b1; sample = 32'h77;
        tick();
        tl_rdv = 1'b0;
        checkOutput("to.pre_data", 64'(req0_data), 64'h77);
        tick();
        req0 = 1'b1; req0_addr = 32'h64;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            tick();
            checkOutput("to.waiting", 64'(tl_read), 64'(1));
        end
        tick();
        checkOutput("to.rdv", 64'(req0_rdv), 64'(1));
        checkOutput("to.data", 64'(req0_data), 64'(0));
        checkOutput("to.err", 64'(timeout_err), 64'(1));
        tick();
        tick();
        checkOutput("to.err_sticky", 64'(timeout_err), 64'(1));

        // tl_rdv on the limit cycle wins
        pulseReset();
        checkOutput("to2.err_clr", 64'(timeout_err), 64'(0));
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < TB_TIMEOUT; i++) tick();
        checkOutput("to2.still_read", 64'(tl_read), 64'(1));
        tl_rdv = 1'b1; sample = 32'hCAFE;
        tick();
        tl_rdv = 1'b0;
        checkOutput("to2.rdv", 64'(req0_rdv), 64'(1));
        checkOutput("to2.data", 64'(req0_data), 64'hCAFE);
        checkOutput("to2.err", 64'(timeout_err), 64'(0));
        tick();
`else
        // Without the timeout the read waits indefinitely
        req0 = 1'b1; req0_addr = 32'h70;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        checkOutput("long.still_read", 64'(tl_read), 64'(1));
        checkOutput("long.no_err", 64'(timeout_err), 64'(0));
        tl_rdv = 1'b1; sample = 32'h5A5A;
        tick();
        tl_rdv = 1'b0;
        checkOutput("long.data", 64'(req0_data), 64'h5A5A);
        tick();
`endif
        pulseReset();
        tick();
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
